// File: rtl/decay_interval_timer.sv
// decay_interval_timer
// Measures the muon decay interval from the coincidence stream. The first
// coincidence rising edge starts the timer (muon stop). The next rising edge
// at least MIN_GAP_CYCLES later stops it (decay electron). The cycle count is
// then offered on a valid/ready port. If no stop arrives within
// MAX_WAIT_CYCLES, a one-cycle timeout pulse is raised instead.
module decay_interval_timer #(
    parameter int CNT_WIDTH       = 16,
    parameter int MIN_GAP_CYCLES  = 5,
    parameter int MAX_WAIT_CYCLES = 2000,
    parameter int DROP_WIDTH      = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  coinc_in,
    input  logic                  out_ready,
    output logic                  out_valid,
    output logic [CNT_WIDTH-1:0]  out_interval,
    output logic                  timeout_pulse,
    output logic                  busy,
    output logic [DROP_WIDTH-1:0] drop_count
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_TIMING = 2'd1;
    localparam logic [1:0] S_OUTPUT = 2'd2;

    localparam logic [CNT_WIDTH-1:0]  CNT_ONE  = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0]  MIN_GAP  = CNT_WIDTH'(MIN_GAP_CYCLES);
    localparam logic [CNT_WIDTH-1:0]  MAX_WAIT = CNT_WIDTH'(MAX_WAIT_CYCLES);
    localparam logic [DROP_WIDTH-1:0] DROP_ONE = DROP_WIDTH'(1);

    logic [1:0]           state;
    logic                 coinc_q;
    logic                 rise;
    logic [CNT_WIDTH-1:0] counter;
    logic [CNT_WIDTH-1:0] elapsed;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [DROP_WIDTH-1:0] sat_inc(input logic [DROP_WIDTH-1:0] v);
        return (&v) ? v : v + DROP_ONE;
    endfunction

    // The counter is cleared at the start edge. The elapsed count N at the
    // current sample is therefore one more than the stored value.
    assign elapsed = counter + CNT_ONE;
    assign rise    = coinc_in & ~coinc_q;
    assign busy    = (state == S_TIMING) || (state == S_OUTPUT);

    // Previous coincidence level. It resets high, so a level held through
    // reset release is not seen as an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            coinc_q <= 1'b1;
        end else begin
            coinc_q <= coinc_in;
        end
    end

    // Measurement FSM: start, qualify stop or time out, then hold the result
    // until the handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_IDLE;
            counter       <= '0;
            out_valid     <= 1'b0;
            out_interval  <= '0;
            timeout_pulse <= 1'b0;
            drop_count    <= '0;
        end else begin
            timeout_pulse <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (rise) begin
                        counter <= '0;
                        state   <= S_TIMING;
                    end
                end
                S_TIMING: begin
                    // A stop exactly at MAX_WAIT is accepted and wins over the timeout.
                    if (rise && (elapsed >= MIN_GAP)) begin
                        out_interval <= elapsed;
                        out_valid    <= 1'b1;
                        state        <= S_OUTPUT;
                    end else if (elapsed >= MAX_WAIT) begin
                        timeout_pulse <= 1'b1;
                        state         <= S_IDLE;
                    end else begin
                        counter <= elapsed;
                    end
                end
                S_OUTPUT: begin
                    // Edges here cannot be measured. They are only tallied,
                    // including one that lands on the handshake cycle.
                    if (rise) begin
                        drop_count <= sat_inc(drop_count);
                    end
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_decay_interval_timer.sv
// tb_decay_interval_timer
// Directed scenarios plus a randomized run. The reference model tracks the
// measurement by absolute cycle numbers: it records the start cycle and
// derives the interval by subtraction.
module tb_decay_interval_timer;

    localparam int CNT_WIDTH  = 16;
    localparam int MIN_GAP    = 5;
    localparam int MAX_WAIT   = 200;
    localparam int DROP_WIDTH = 8;
    localparam int DROP_MAX   = (1 << DROP_WIDTH) - 1;

    logic                  clk;
    logic                  rst;
    logic                  coinc_in;
    logic                  out_ready;
    logic                  out_valid;
    logic [CNT_WIDTH-1:0]  out_interval;
    logic                  timeout_pulse;
    logic                  busy;
    logic [DROP_WIDTH-1:0] drop_count;

    decay_interval_timer #(
        .CNT_WIDTH      (CNT_WIDTH),
        .MIN_GAP_CYCLES (MIN_GAP),
        .MAX_WAIT_CYCLES(MAX_WAIT),
        .DROP_WIDTH     (DROP_WIDTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .coinc_in     (coinc_in),
        .out_ready    (out_ready),
        .out_valid    (out_valid),
        .out_interval (out_interval),
        .timeout_pulse(timeout_pulse),
        .busy         (busy),
        .drop_count   (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state, all in absolute cycle terms.
    int cyc       = 0;
    int start_cyc = 0;
    bit prev_lvl  = 1'b1;
    bit measuring = 1'b0;
    bit pending   = 1'b0;
    int m_valid   = 0;
    int m_interval = 0;
    int m_timeout = 0;
    int m_drop    = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        prev_lvl   = 1'b1;
        measuring  = 1'b0;
        pending    = 1'b0;
        m_valid    = 0;
        m_interval = 0;
        m_timeout  = 0;
        m_drop     = 0;
    endtask

    // Apply the rules to one sampled clock edge.
    task automatic model_edge(input bit c, input bit r);
        bit rise_e;
        int n;
        cyc++;
        rise_e    = c && !prev_lvl;
        prev_lvl  = c;
        m_timeout = 0;
        if (pending) begin
            if (rise_e && m_drop < DROP_MAX) m_drop++;
            if (r) begin
                pending = 1'b0;
                m_valid = 0;
            end
        end else if (measuring) begin
            n = cyc - start_cyc;
            if (rise_e && n >= MIN_GAP && n <= MAX_WAIT) begin
                m_interval = n;
                m_valid    = 1;
                pending    = 1'b1;
                measuring  = 1'b0;
            end else if (n >= MAX_WAIT) begin
                m_timeout = 1;
                measuring = 1'b0;
            end
        end else if (rise_e) begin
            measuring = 1'b1;
            start_cyc = cyc;
        end
    endtask

    task automatic check_all();
        chk("out_valid",     32'(out_valid),     32'(m_valid));
        chk("out_interval",  32'(out_interval),  32'(m_interval));
        chk("timeout_pulse", 32'(timeout_pulse), 32'(m_timeout));
        chk("busy",          32'(busy),          32'(measuring || pending));
        chk("drop_count",    32'(drop_count),    32'(m_drop));
    endtask

    // Drive one cycle of inputs, let the edge happen, then compare 1 ns later.
    task automatic cycle(input bit c, input bit r);
        coinc_in  = c;
        out_ready = r;
        @(posedge clk);
        model_edge(c, r);
        #1;
        check_all();
    endtask

    // Start rise, then a stop rise exactly gap cycles later.
    task automatic run_gap(input int gap, input bit r);
        cycle(1'b1, r);
        repeat (gap - 1) cycle(1'b0, r);
        cycle(1'b1, r);
    endtask

    // Assert reset between edges and confirm the outputs clear without a clock.
    task automatic async_reset(input string tag);
        #2 rst = 1'b1;
        #1;
        model_reset();
        chk({tag, "_valid"},    32'(out_valid),     32'd0);
        chk({tag, "_interval"}, 32'(out_interval),  32'd0);
        chk({tag, "_timeout"},  32'(timeout_pulse), 32'd0);
        chk({tag, "_busy"},     32'(busy),          32'd0);
        chk({tag, "_drop"},     32'(drop_count),    32'd0);
        #2 rst = 1'b0;
    endtask

    initial begin
        bit lvl;
        rst       = 1'b1;
        coinc_in  = 1'b0;
        out_ready = 1'b0;
        #2;
        chk("rst_valid", 32'(out_valid),  32'd0);
        chk("rst_busy",  32'(busy),       32'd0);
        chk("rst_drop",  32'(drop_count), 32'd0);
        chk("rst_intv",  32'(out_interval), 32'd0);
        #10 rst = 1'b0;
        model_reset();
        repeat (3) cycle(1'b0, 1'b0);

        // 1: plain measurement of 50 cycles with ready high
        run_gap(50, 1'b1);
        chk("t1_valid", 32'(out_valid), 32'd1);
        chk("t1_interval", 32'(out_interval), 32'd50);
        cycle(1'b0, 1'b1);
        chk("t1_valid_drop", 32'(out_valid), 32'd0);
        chk("t1_busy_idle", 32'(busy), 32'd0);
        repeat (3) cycle(1'b0, 1'b1);

        // 2: early ringing at N=3 ignored, stop at N=40
        cycle(1'b1, 1'b1);
        cycle(1'b0, 1'b1);
        cycle(1'b0, 1'b1);
        cycle(1'b1, 1'b1);
        repeat (36) cycle(1'b0, 1'b1);
        cycle(1'b1, 1'b1);
        chk("t2_interval", 32'(out_interval), 32'd40);
        chk("t2_drop", 32'(drop_count), 32'd0);
        cycle(1'b0, 1'b1);
        repeat (2) cycle(1'b0, 1'b1);

        // 3: no stop -> timeout at N=MAX_WAIT
        cycle(1'b1, 1'b1);
        repeat (MAX_WAIT - 1) cycle(1'b0, 1'b1);
        chk("t3_no_pulse_early", 32'(timeout_pulse), 32'd0);
        cycle(1'b0, 1'b1);
        chk("t3_pulse", 32'(timeout_pulse), 32'd1);
        chk("t3_busy", 32'(busy), 32'd0);
        cycle(1'b0, 1'b1);
        chk("t3_pulse_end", 32'(timeout_pulse), 32'd0);
        chk("t3_no_valid", 32'(out_valid), 32'd0);

        // 4: stop exactly at MAX_WAIT is accepted, no timeout
        run_gap(MAX_WAIT, 1'b1);
        chk("t4_interval", 32'(out_interval), 32'(MAX_WAIT));
        chk("t4_no_pulse", 32'(timeout_pulse), 32'd0);
        cycle(1'b0, 1'b1);
        chk("t4_no_pulse_after", 32'(timeout_pulse), 32'd0);
        repeat (2) cycle(1'b0, 1'b1);

        // 5: backpressure with two edges during the wait
        run_gap(30, 1'b0);
        for (int k = 0; k < 40; k++) cycle((k == 10 || k == 25), 1'b0);
        chk("t5_valid_held", 32'(out_valid), 32'd1);
        chk("t5_interval", 32'(out_interval), 32'd30);
        chk("t5_drop", 32'(drop_count), 32'd2);
        cycle(1'b0, 1'b1);
        chk("t5_handshake", 32'(out_valid), 32'd0);
        chk("t5_idle", 32'(busy), 32'd0);
        repeat (2) cycle(1'b0, 1'b1);

        // drop_count saturation, plus an edge on the handshake cycle
        run_gap(10, 1'b0);
        repeat (300) begin
            cycle(1'b0, 1'b0);
            cycle(1'b1, 1'b0);
        end
        chk("sat_drop", 32'(drop_count), 32'(DROP_MAX));
        cycle(1'b0, 1'b0);
        cycle(1'b1, 1'b1);
        chk("sat_hold", 32'(drop_count), 32'(DROP_MAX));
        repeat (2) cycle(1'b0, 1'b1);

        // 6: reset mid-measurement with coinc held high
        cycle(1'b1, 1'b1);
        repeat (MIN_GAP * 4) cycle(1'b1, 1'b1);
        chk("t6_busy_before", 32'(busy), 32'd1);
        async_reset("t6");
        repeat (5) cycle(1'b1, 1'b1);
        chk("t6_no_start", 32'(busy), 32'd0);
        cycle(1'b0, 1'b1);
        cycle(1'b1, 1'b1);
        chk("t6_restart", 32'(busy), 32'd1);
        repeat (MIN_GAP + 2) cycle(1'b0, 1'b1);
        cycle(1'b1, 1'b1);
        cycle(1'b0, 1'b1);

        // Reset while a result is waiting clears it
        run_gap(8, 1'b0);
        cycle(1'b0, 1'b0);
        async_reset("rst_out");
        repeat (3) cycle(1'b0, 1'b1);

        // Randomized run against the model
        lvl = 1'b0;
        repeat (4000) begin
            if (lvl) lvl = ($urandom_range(0, 1) == 1);
            else     lvl = ($urandom_range(0, 99) < 4);
            cycle(lvl, ($urandom_range(0, 3) != 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
